// File: rtl/lcd_fetch_pkg.sv
// lcd_fetch_pkg: shared FSM state type and default parameters for the LCD line fetch controller
package lcd_fetch_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SPACE, REQ, XFER, DONE} state_t;
  localparam int DEF_FRAME_PIX = 384000;
  localparam int DEF_BURST_LEN = 256;
  localparam int DEF_FIFO_DEPTH = 1024;
  localparam int DEF_FIFO_AW = 10;
  localparam int DEF_ADDR_W = 24;
endpackage

// File: rtl/lcd_sync_edge.sv
// lcd_sync_edge: registered falling-edge detector
// Ports: clk, rst_n (async active-low), i_d level input, o_fall high for the cycle i_d is first seen low.
// The register resets high, so an input idling high after reset gives no false edge.
module lcd_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_fall
);
  logic r_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_d <= 1'b1;
    else r_d <= i_d;
  assign o_fall = r_d & ~i_d;
endmodule

// File: rtl/lcd_line_fetch_ctrl.sv
// lcd_line_fetch_ctrl: fetches one frame from memory into the display line FIFO in bursts
// Ports: rgb_clk/rst_n clock and async active-low reset; rgb_vs (active-low vsync) and rgb_de from the display;
// fifo_level in, fifo_clr flush pulse out; frame_base start address; rd_req/rd_addr/rd_len/rd_ack/rd_done
// arbiter handshake; underrun sticky per-frame flag; underrun_cnt counter; busy outside IDLE/DONE.
// Macro LCD_FETCH_STAT_EN enables the saturating underrun counter; otherwise underrun_cnt is tied to 0.
module lcd_line_fetch_ctrl
  import lcd_fetch_pkg::*;
#(
  parameter int FRAME_PIX = DEF_FRAME_PIX,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_AW = DEF_FIFO_AW,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              rgb_clk,
  input  logic              rst_n,
  input  logic              rgb_vs,
  input  logic              rgb_de,
  input  logic [FIFO_AW:0]  fifo_level,
  output logic              fifo_clr,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [8:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              underrun,
  output logic [15:0]       underrun_cnt,
  output logic              busy
);
  localparam int RW = $clog2(FRAME_PIX + 1);
  state_t r_state, w_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [RW-1:0] r_rem;
  logic r_pend, w_fs, w_space, w_ur;
  logic [8:0] w_len;
  lcd_sync_edge u_vs (.clk(rgb_clk), .rst_n(rst_n), .i_d(rgb_vs), .o_fall(w_fs));
  assign w_space = 32'(fifo_level) <= 32'(FIFO_DEPTH - BURST_LEN);
  assign w_len = 32'(r_rem) >= 32'(BURST_LEN) ? 9'(BURST_LEN) : 9'(r_rem);
  assign w_ur = rgb_de && fifo_level == '0 && r_state != IDLE;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_nxt = w_fs ? CLEAR : r_state;
      CLEAR:      w_nxt = WAIT_SPACE;
      WAIT_SPACE: w_nxt = w_fs ? CLEAR : r_rem == '0 ? DONE : w_space ? REQ : WAIT_SPACE;
      REQ:        w_nxt = rd_ack ? XFER : w_fs ? CLEAR : REQ;
      XFER:       w_nxt = !rd_done ? XFER : (r_pend || w_fs) ? CLEAR : WAIT_SPACE;
      default:    w_nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge rgb_clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      rd_req <= 1'b0;
      fifo_clr <= 1'b0;
      busy <= 1'b0;
      rd_addr <= '0;
      rd_len <= '0;
      r_ptr <= '0;
      r_rem <= '0;
      r_pend <= 1'b0;
      underrun <= 1'b0;
    end else begin
      r_state <= w_nxt;
      rd_req <= w_nxt == REQ;
      fifo_clr <= w_nxt == CLEAR;
      busy <= !(w_nxt inside {IDLE, DONE});
      if (w_nxt == REQ && r_state != REQ) begin
        rd_addr <= r_ptr;
        rd_len <= w_len;
      end
      if (r_state == CLEAR) begin
        r_ptr <= frame_base;
        r_rem <= RW'(FRAME_PIX);
      end
      if (r_state == XFER && rd_done) begin
        r_ptr <= r_ptr + ADDR_W'(rd_len);
        r_rem <= r_rem - RW'(rd_len);
      end
      // A frame start seen once the arbiter owns a burst is deferred until that burst completes.
      if (w_nxt == CLEAR) r_pend <= 1'b0;
      else if (w_fs && (r_state == XFER || (r_state == REQ && rd_ack))) r_pend <= 1'b1;
      underrun <= r_state == CLEAR ? 1'b0 : underrun | w_ur;
    end
`ifdef LCD_FETCH_STAT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge rgb_clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (w_ur && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  assign underrun_cnt = r_cnt;
`else
  assign underrun_cnt = '0;
`endif
endmodule

// File: doc/lcd_line_fetch_ctrl.md
LCD_LINE_FETCH_CTRL -- requirements
Module: lcd_line_fetch_ctrl

Interface
REQ-001 SHALL have parameter FRAME_PIX, default 384000: pixels (16-bit words) per frame.
REQ-002 SHALL have parameter BURST_LEN, default 256: maximum words per read request.
REQ-003 SHALL have parameter FIFO_DEPTH, default 1024: display line FIFO depth in words.
REQ-004 SHALL have parameter FIFO_AW, default 10: FIFO address width; level port is FIFO_AW+1 bits.
REQ-005 SHALL have parameter ADDR_W, default 24: word address width.
REQ-006 SHALL have port rgb_clk, input, 1: pixel clock, the only clock.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port rgb_vs, input, 1: vertical sync, active low.
REQ-009 SHALL have port rgb_de, input, 1: display pixel-valid, meaning one FIFO word is consumed.
REQ-010 SHALL have port fifo_level, input, FIFO_AW+1: words currently held in the FIFO.
REQ-011 SHALL have port fifo_clr, output, 1: FIFO flush pulse.
REQ-012 SHALL have port frame_base, input, ADDR_W: frame start address.
REQ-013 SHALL have port rd_req, output, 1: read request to the memory arbiter.
REQ-014 SHALL have port rd_addr, output, ADDR_W: request start address.
REQ-015 SHALL have port rd_len, output, 9: request length in words.
REQ-016 SHALL have port rd_ack, input, 1: request accepted.
REQ-017 SHALL have port rd_done, input, 1: single-cycle pulse marking the last word of the accepted burst written to the FIFO.
REQ-018 SHALL have port underrun, output, 1: sticky flag for the current frame.
REQ-019 SHALL have port underrun_cnt, output, 16: underrun counter.
REQ-020 SHALL have port busy, output, 1: high in every state except IDLE and DONE.

Function
REQ-021 SHALL register rgb_vs and detect frame start as a falling edge, using the registered value.
REQ-022 SHALL implement states IDLE, CLEAR, WAIT_SPACE, REQ, XFER and DONE.
REQ-023 In IDLE or DONE, on frame start, SHALL enter CLEAR.
REQ-024 SHALL assert fifo_clr for exactly the one cycle spent in CLEAR.
REQ-025 In CLEAR, SHALL latch frame_base into the address pointer, set remaining to FRAME_PIX, clear underrun, and go to WAIT_SPACE.
REQ-026 In WAIT_SPACE, if remaining==0, SHALL go to DONE.
REQ-027 In WAIT_SPACE, if remaining>0 and fifo_level <= FIFO_DEPTH-BURST_LEN, SHALL go to REQ; otherwise it SHALL stay in WAIT_SPACE.
REQ-028 In REQ, SHALL hold rd_req=1 with rd_addr equal to the pointer and rd_len = min(BURST_LEN, remaining), stable until rd_ack.
REQ-029 On rd_ack in REQ, SHALL deassert rd_req in the next cycle and go to XFER.
REQ-030 In XFER, on rd_done, SHALL add rd_len to the pointer, subtract rd_len from remaining, and go to WAIT_SPACE.
REQ-031 SHALL perform pointer arithmetic modulo 2^ADDR_W.
REQ-032 SHALL size remaining to ceil(log2(FRAME_PIX+1)) bits.
REQ-033 On frame start in WAIT_SPACE, SHALL go to CLEAR.
REQ-034 On frame start in REQ with rd_ack low in the same cycle, SHALL drop rd_req next cycle and go to CLEAR.
REQ-035 On frame start in REQ with rd_ack high in the same cycle, SHALL treat the request as accepted.
REQ-036 On frame start in REQ with rd_ack high, SHALL set a pending flag.
REQ-037 On frame start in XFER, SHALL set the pending flag and finish the burst.
REQ-038 On rd_done with pending set, SHALL go to CLEAR, not WAIT_SPACE, and clear pending.
REQ-039 Frame start in CLEAR SHALL be ignored.
REQ-040 SHALL set underrun when rgb_de=1 and fifo_level==0 while busy or DONE.
REQ-041 rd_done outside XFER SHALL be ignored.

Reset
REQ-042 On rst_n low, SHALL asynchronously reset state to IDLE.
REQ-043 On rst_n low, SHALL drive rd_req, fifo_clr, underrun and busy to 0.
REQ-044 On rst_n low, SHALL reset rd_addr, rd_len, the pointer, remaining, pending and underrun_cnt to 0.
REQ-045 On rst_n low, SHALL reset the vs register to 1, so that no false edge follows reset.
REQ-046 Reset mid-burst SHALL abandon the burst; the arbiter is reset with it.

Configuration
REQ-047 With macro LCD_FETCH_STAT_EN defined, underrun_cnt SHALL increment once per cycle satisfying REQ-040, saturate at 16'hFFFF, and clear only on reset.
REQ-048 Without LCD_FETCH_STAT_EN, underrun_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-049 Package lcd_fetch_pkg SHALL hold the state enum and the default parameter constants.
REQ-050 Sub-module lcd_sync_edge SHALL provide the registered falling-edge detector on rgb_vs.
REQ-051 The FSM and datapath SHALL reside in lcd_line_fetch_ctrl.

Verification
REQ-052 Bench: FRAME_PIX=1000, BURST_LEN=256, fifo_level=0, rd_ack 2 cycles after rd_req, rd_done 10 cycles after ack, vs falling edge, frame_base=0x1000 -> one-cycle fifo_clr, then requests (0x1000,256), (0x1100,256), (0x1200,256), (0x1300,232), then DONE with busy=0.
REQ-053 Bench: fifo_level=800 (>768) -> no rd_req; fifo_level drops to 768 -> rd_req within 2 cycles.
REQ-054 Bench: frame start while in REQ, rd_ack held low -> rd_req drops next cycle, fifo_clr pulses, next request uses the new frame_base.
REQ-055 Bench: frame start during XFER -> no fifo_clr until rd_done, then CLEAR and restart at the new frame_base.
REQ-056 Bench: rgb_de=1 for 3 cycles with fifo_level=0 -> underrun=1; with LCD_FETCH_STAT_EN, underrun_cnt=3; next frame start -> underrun=0 and underrun_cnt still 3.
REQ-057 Bench: rst_n pulsed low mid-XFER -> all outputs 0 immediately, state IDLE, and no fifo_clr until the next vs falling edge.
